inst_fetch_cache: RTL and testbench

Direct-mapped instruction cache that sits directly upstream of the fetch stage. It takes a byte PC and returns the whole 128-byte line containing it, with a registered hit flag. On a miss it refills the line from the memory read port, one 32-bit word per beat. Fetch walks the returned line word by word and steps its PC by 128 at the end of each line.

---
 rtl/inst_fetch_cache_pkg.sv | 29 ++
 rtl/inst_fetch_cache_icache_array.sv | 65 ++++++
 rtl/inst_fetch_cache.sv | 165 ++++++++++++++++
 tb/tb_inst_fetch_cache.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_cache_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_cache_pkg
// Shared definitions for the instruction fetch cache: word/line geometry,
// byte-offset width, beat counter width and the refill FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package inst_fetch_cache_pkg;

   localparam int ADDR_W         = 32;
   localparam int WORD_SIZE      = 32;
   localparam int BLOCK_SIZE     = 1024;
   localparam int LINE_BYTES     = 128;
   localparam int WORDS_PER_LINE = BLOCK_SIZE / WORD_SIZE;
   localparam int OFFSET_W       = 7;
   localparam int BEAT_W         = $clog2(WORDS_PER_LINE);

   // Refill FSM encoding
   typedef logic [1:0] state_t;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_FILL = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // Base byte address of the line that holds a given PC.
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] pc);
      return {pc[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/inst_fetch_cache_icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Storage for a direct-mapped cache: LINES entries of (valid, tag, line data).
// Synchronous write, combinational read. i_clr clears every valid bit; tags
// and data are left untouched.
// Ports:
//   clk        clock
//   i_clr      clear all valid bits on this edge (has priority over a write)
//   i_wr_en    install i_wr_tag/i_wr_data at i_wr_idx and mark it valid
//   i_wr_idx   line index to write
//   i_wr_tag   tag to write
//   i_wr_data  line data to write
//   i_rd_idx   line index to read
//   o_rd_valid valid bit of the addressed line
//   o_rd_tag   tag of the addressed line
//   o_rd_data  data of the addressed line
// -----------------------------------------------------------------------------
module icache_array
   import inst_fetch_cache_pkg::*;
#(
   parameter int LINES = 8,
   parameter int IDX_W = 3,
   parameter int TAG_W = 22
) (
   input  logic                  clk,
   input  logic                  i_clr,
   input  logic                  i_wr_en,
   input  logic [IDX_W-1:0]      i_wr_idx,
   input  logic [TAG_W-1:0]      i_wr_tag,
   input  logic [BLOCK_SIZE-1:0] i_wr_data,
   input  logic [IDX_W-1:0]      i_rd_idx,
   output logic                  o_rd_valid,
   output logic [TAG_W-1:0]      o_rd_tag,
   output logic [BLOCK_SIZE-1:0] o_rd_data
);

   logic [LINES-1:0]      r_valid;
   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [BLOCK_SIZE-1:0] r_data [LINES];

   // Valid bits are the only state cleared; each line has its own flop.
   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk) begin
            if (i_clr) begin
               r_valid[gi] <= 1'b0;
            end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
               r_valid[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/inst_fetch_cache.sv
// -----------------------------------------------------------------------------
// inst_fetch_cache
// Direct-mapped instruction cache returning whole 128-byte lines to fetch.
// Hits answer one cycle after the lookup edge; misses issue a line refill
// request and collect 32 ascending 32-bit beats before installing the line.
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   req         lookup request
//   pc_in       byte PC (low 7 bits ignored)
//   hit         registered: block_out holds the line of the last sampled PC
//   block_out   line data, word 0 at the top bits
//   mem_req     refill request, held until mem_gnt
//   mem_addr    refill line base address, stable while mem_req=1
//   mem_gnt     memory accepts the request
//   mem_rvalid  refill beat valid
//   mem_rdata   refill beat data, ascending word order
// -----------------------------------------------------------------------------
module inst_fetch_cache
   import inst_fetch_cache_pkg::*;
#(
   parameter int LINES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic [ADDR_W-1:0]     pc_in,
   output logic                  hit,
   output logic [BLOCK_SIZE-1:0] block_out,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [WORD_SIZE-1:0]  mem_rdata
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

   state_t                r_state;
   logic                  r_hit;
   logic [BLOCK_SIZE-1:0] r_block_out;
   logic                  r_mem_req;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [BEAT_W-1:0]     r_beat;
   logic [IDX_W-1:0]      r_idx;
   logic [TAG_W-1:0]      r_tag;
   logic [BLOCK_SIZE-1:0] r_fill_buf;

   logic [IDX_W-1:0]      w_pc_idx;
   logic [TAG_W-1:0]      w_pc_tag;
   logic                  w_rd_valid;
   logic [TAG_W-1:0]      w_rd_tag;
   logic [BLOCK_SIZE-1:0] w_rd_data;
   logic                  w_lookup_hit;
   logic [BLOCK_SIZE-1:0] w_fill_line;
   logic                  w_last_beat;
   logic                  w_wr_en;

   assign w_pc_idx     = pc_in[OFFSET_W +: IDX_W];
   assign w_pc_tag     = pc_in[ADDR_W-1 : OFFSET_W+IDX_W];
   assign w_lookup_hit = w_rd_valid && (w_rd_tag == w_pc_tag);

   // Fill buffer with the current beat merged in. Installing this (rather
   // than r_fill_buf) lets the edge that takes the last beat also write the
   // array, so no extra cycle is spent.
   generate
      for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_fill_word
         assign w_fill_line[BLOCK_SIZE-1-WORD_SIZE*gi -: WORD_SIZE] =
            (r_beat == BEAT_W'(gi)) ? mem_rdata
                                    : r_fill_buf[BLOCK_SIZE-1-WORD_SIZE*gi -: WORD_SIZE];
      end
   endgenerate

   assign w_last_beat = mem_rvalid && (r_beat == BEAT_W'(WORDS_PER_LINE-1));
   assign w_wr_en     = (r_state == ST_FILL) && w_last_beat;

   icache_array #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk        (clk),
      .i_clr      (!rst_n),
      .i_wr_en    (w_wr_en),
      .i_wr_idx   (r_idx),
      .i_wr_tag   (r_tag),
      .i_wr_data  (w_fill_line),
      .i_rd_idx   (w_pc_idx),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data)
   );

   // Control path: everything that reset must put in a known state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_hit       <= 1'b0;
         r_block_out <= '0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_beat      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!req) begin
                  r_hit <= 1'b0;
               end else if (w_lookup_hit) begin
                  r_hit       <= 1'b1;
                  r_block_out <= w_rd_data;
               end else begin
                  r_hit      <= 1'b0;
                  r_mem_addr <= line_base(pc_in);
                  r_mem_req  <= 1'b1;
                  r_state    <= ST_REQ;
               end
            end
            ST_REQ: begin
               r_hit <= 1'b0;
               if (mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_beat    <= '0;
                  r_state   <= ST_FILL;
               end
            end
            ST_FILL: begin
               r_hit <= 1'b0;
               if (mem_rvalid) begin
                  r_beat <= r_beat + BEAT_W'(1);
                  if (w_last_beat) begin
                     r_state <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               // Presents the line that was filled, even if fetch has moved on.
               r_hit       <= 1'b1;
               r_block_out <= r_fill_buf;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Data path: miss bookkeeping and fill buffer need no reset value.
   always_ff @(posedge clk) begin
      if ((r_state == ST_IDLE) && req && !w_lookup_hit) begin
         r_idx <= w_pc_idx;
         r_tag <= w_pc_tag;
      end
      if ((r_state == ST_FILL) && mem_rvalid) begin
         r_fill_buf <= w_fill_line;
      end
   end

   assign hit       = r_hit;
   assign block_out = r_block_out;
   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_inst_fetch_cache.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_cache
// Directed bench for inst_fetch_cache: cold miss, hit, conflict eviction,
// memory backpressure, reset during a fill with stray beats, and PC change
// during a fill. Inputs change 1 time unit after the rising edge and outputs
// are sampled at that point.
// -----------------------------------------------------------------------------
module tb_inst_fetch_cache;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic [31:0]   pc_in = '0;
   logic          hit;
   logic [1023:0] block_out;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic          mem_gnt = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [31:0]   mem_rdata = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   inst_fetch_cache #(.LINES(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .pc_in      (pc_in),
      .hit        (hit),
      .block_out  (block_out),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input int k);
      return block_out[1023-32*k -: 32];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every word of block_out must be dbase + word number.
   task automatic check_line(input string tag, input logic [31:0] dbase);
      for (int k = 0; k < 32; k++) begin
         check($sformatf("%s_w%0d", tag, k), word_of(k), dbase + 32'(k));
      end
   endtask

   // One complete miss: lookup at edge 0, grant at edge 1+gnt_dly, beats
   // every edge (or every second edge when gappy). pc_in switches to pc_alt
   // before edge chg_at (0 = never). Expects hit on the first edge after the
   // edge that took beat 31 and the latched line in block_out.
   task automatic run_miss(input string tag, input logic [31:0] pc, input logic [31:0] dbase,
                           input int gnt_dly, input bit gappy,
                           input logic [31:0] pc_alt, input int chg_at);
      int g;
      int beat;
      int lat;
      int req_cycles;
      int addr_bad;
      logic [31:0] base;
      g = 1 + gnt_dly;
      beat = 0;
      lat = -1;
      req_cycles = 0;
      addr_bad = 0;
      base = {pc[31:7], 7'b0};
      req = 1'b1;
      pc_in = pc;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      step();
      check($sformatf("%s_memreq", tag), 32'(mem_req), 32'd1);
      check($sformatf("%s_addr", tag), mem_addr, base);
      check($sformatf("%s_hit_miss", tag), 32'(hit), 32'd0);
      for (int n = 1; n < 400; n++) begin
         if (mem_req) begin
            req_cycles++;
            if (mem_addr !== base) addr_bad++;
         end
         if (n == chg_at) pc_in = pc_alt;
         mem_gnt = (n == g);
         if (n > g && beat < 32 && (!gappy || ((n - g) % 2 == 0))) begin
            mem_rvalid = 1'b1;
            mem_rdata = dbase + 32'(beat);
            beat++;
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
         end
         step();
         if (hit) begin
            lat = n;
            break;
         end
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      check($sformatf("%s_latency", tag), 32'(lat), gappy ? 32'(g + 65) : 32'(g + 33));
      check($sformatf("%s_req_cycles", tag), 32'(req_cycles), 32'(g));
      check($sformatf("%s_addr_stable", tag), 32'(addr_bad), 32'd0);
      check_line(tag, dbase);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst_n = 1'b0;
      step();
      step();
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_memreq", 32'(mem_req), 32'd0);
      check("rst_memaddr", mem_addr, 32'd0);
      check("rst_w0", word_of(0), 32'd0);
      check("rst_w31", word_of(31), 32'd0);
      rst_n = 1'b1;

      // 1: cold miss, zero-wait memory
      run_miss("t1", 32'h0, 32'h1000_0000, 0, 1'b0, 32'h0, 0);
      check("t1_w0_top", block_out[1023:992], 32'h1000_0000);
      check("t1_w31_low", block_out[31:0], 32'h1000_001F);

      // 2: hit within the same line, then idle
      req = 1'b1;
      pc_in = 32'h4C;
      step();
      check("t2_hit", 32'(hit), 32'd1);
      check("t2_memreq", 32'(mem_req), 32'd0);
      check_line("t2", 32'h1000_0000);
      req = 1'b0;
      step();
      check("t2_idle_hit", 32'(hit), 32'd0);

      // 3: conflict on index 0, then the evicted line misses again
      run_miss("t3a", 32'h400, 32'h2000_0000, 0, 1'b0, 32'h0, 0);
      run_miss("t3b", 32'h0, 32'h3000_0000, 0, 1'b0, 32'h0, 0);

      // 4: grant 5 cycles late, beats every other cycle
      run_miss("t4", 32'h100, 32'h4000_0000, 5, 1'b1, 32'h0, 0);

      // 5: reset after 10 beats, then stray beats
      req = 1'b1;
      pc_in = 32'h180;
      step();
      check("t5_memreq", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      for (int k = 0; k < 10; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata = 32'h6000_0000 + 32'(k);
         step();
      end
      check("t5_fill_hit", 32'(hit), 32'd0);
      rst_n = 1'b0;
      mem_rvalid = 1'b0;
      req = 1'b0;
      step();
      check("t5_rst_hit", 32'(hit), 32'd0);
      check("t5_rst_memreq", 32'(mem_req), 32'd0);
      check("t5_rst_memaddr", mem_addr, 32'd0);
      check("t5_rst_w0", word_of(0), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata = 32'hBAD0_0000 + 32'(k);
         step();
         check($sformatf("t5_stray%0d_hit", k), 32'(hit), 32'd0);
         check($sformatf("t5_stray%0d_memreq", k), 32'(mem_req), 32'd0);
      end
      mem_rvalid = 1'b0;
      // line 0 was valid before the reset, so this must miss
      run_miss("t5", 32'h0, 32'h5000_0000, 0, 1'b0, 32'h0, 0);

      // 6: PC moves to 0x80 during the fill of 0x800 (index 0)
      run_miss("t6a", 32'h800, 32'h7000_0000, 0, 1'b0, 32'h80, 10);
      run_miss("t6b", 32'h80, 32'h8000_0000, 0, 1'b0, 32'h0, 0);
      req = 1'b1;
      pc_in = 32'h800;
      step();
      check("t6_relookup_hit", 32'(hit), 32'd1);
      check("t6_relookup_memreq", 32'(mem_req), 32'd0);
      check_line("t6_relookup", 32'h7000_0000);
      req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
